// File: rtl/scoreboard_regfile_if.sv
// -----------------------------------------------------------------------------
// scoreboard_regfile_if
//
// Purpose:
//   Groups the read, issue, write-back and status signals of the
//   scoreboarded register file into one bundle. The decode stage
//   (master) drives addresses, issue and write-back requests. The
//   register file (slave) returns read data, busy flags, issue-ready
//   and the sticky error flag.
//
// Handshake:
//   Issue uses valid/ready semantics. An issue is accepted on a rising
//   clock edge only when iss_en_i and iss_ready_o are both high in that
//   cycle. iss_ready_o is combinational and never depends on iss_en_i.
//   An issue presented while iss_ready_o is low is dropped and flagged
//   on err_o. Write-back (wr_en_i) and flush (flush_i) are plain strobes
//   with no back-pressure.
//
// Signals:
//   rd_addr_i   NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o   NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy_o   NUM_RD         port k still has an outstanding write after this cycle
//   iss_en_i    1              issue of an instruction writing iss_addr_i
//   iss_addr_i  ADDR_W         destination of the issued instruction
//   iss_ready_o 1              an issue to iss_addr_i would be accepted now
//   wr_en_i     1              write-back strobe
//   wr_addr_i   ADDR_W         write-back address
//   wr_data_i   DATA_W         write-back data
//   flush_i     1              discard all pending counts
//   err_o       1              sticky protocol error flag
// -----------------------------------------------------------------------------
interface scoreboard_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic                     iss_en_i;
    logic [ADDR_W-1:0]        iss_addr_i;
    logic                     iss_ready_o;
    logic                     wr_en_i;
    logic [ADDR_W-1:0]        wr_addr_i;
    logic [DATA_W-1:0]        wr_data_i;
    logic                     flush_i;
    logic                     err_o;

    // Decode-stage side.
    modport master (
        output rd_addr_i, iss_en_i, iss_addr_i, wr_en_i, wr_addr_i, wr_data_i, flush_i,
        input  rd_data_o, rd_busy_o, iss_ready_o, err_o
    );

    // Register-file side.
    modport slave (
        input  rd_addr_i, iss_en_i, iss_addr_i, wr_en_i, wr_addr_i, wr_data_i, flush_i,
        output rd_data_o, rd_busy_o, iss_ready_o, err_o
    );
endinterface

// File: rtl/scoreboard_regfile.sv
// -----------------------------------------------------------------------------
// scoreboard_regfile
//
// Purpose:
//   Register file for the pipelined datapath. It has NUM_RD
//   combinational read ports with same-cycle write-through bypass. A
//   per-register pending-write counter tracks in-flight writes, so
//   decode can see RAW hazards (rd_busy_o) and throttle issue
//   (iss_ready_o) without a separate hazard unit.
//
// Ports:
//   clk_i   clock; all state updates on the rising edge
//   rst_i   synchronous, active-high reset
//   bus     scoreboard_regfile_if.slave (read / issue / write-back / status)
//
// State:
//   mem[r]  register contents
//   cnt[r]  number of issued-but-not-written-back writes to r
//   err_q   sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module scoreboard_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    scoreboard_regfile_if.slave   bus
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [CNT_W-1:0]  cnt [NUM_REGS];
    logic              err_q;

    // Register 0 is hardwired to zero only when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // -------------------------------------------------------------------------
    // Write-back side
    // -------------------------------------------------------------------------
    logic              wr_commit;   // write lands in storage
    logic [CNT_W-1:0]  wr_cnt;      // pending count of the write target
    logic              wr_frees;    // write retires one pending slot
    logic              underflow;   // write to a register with nothing pending

    assign wr_commit = bus.wr_en_i && !is_zero_reg(bus.wr_addr_i);
    assign wr_cnt    = cnt[bus.wr_addr_i];
    assign wr_frees  = wr_commit && (wr_cnt != '0);
    assign underflow = wr_commit && (wr_cnt == '0);

    // -------------------------------------------------------------------------
    // Issue side
    // -------------------------------------------------------------------------
    logic              iss_to_zero;
    logic [CNT_W-1:0]  iss_cnt;
    logic              iss_slot_freed;
    logic              iss_ready;
    logic              iss_accept;
    logic              overflow;

    assign iss_to_zero    = is_zero_reg(bus.iss_addr_i);
    assign iss_cnt        = cnt[bus.iss_addr_i];
    // A full counter still accepts an issue when the same register is
    // retiring a write this cycle: the net count does not change.
    assign iss_slot_freed = wr_frees && (bus.wr_addr_i == bus.iss_addr_i);
    assign iss_ready      = iss_to_zero || (iss_cnt != CNT_MAX) || iss_slot_freed;
    // Issues to a hardwired-zero register are accepted but never counted.
    assign iss_accept     = bus.iss_en_i && iss_ready && !iss_to_zero;
    assign overflow       = bus.iss_en_i && !iss_ready;

    assign bus.iss_ready_o = iss_ready;
    assign bus.err_o       = err_q;

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  pend;
        logic              bypass;

        assign addr   = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
        assign pend   = cnt[addr];
        assign bypass = bus.wr_en_i && (bus.wr_addr_i == addr);

        assign bus.rd_data_o[k*DATA_W +: DATA_W] =
            is_zero_reg(addr) ? '0 :
            bypass            ? bus.wr_data_i :
                                mem[addr];

        // When the last outstanding write is being bypassed this cycle the
        // reader already sees the final value, so it is no longer busy.
        assign bus.rd_busy_o[k] = (pend != '0) && !(bypass && (pend == CNT_ONE));
    end

    // -------------------------------------------------------------------------
    // State update
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
                cnt[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wr_commit) begin
                mem[bus.wr_addr_i] <= bus.wr_data_i;
            end

            if (bus.flush_i) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    cnt[r] <= '0;
                end
            end else begin
                // At most one register is incremented and one decremented.
                // When both hit the same register its count is unchanged.
                if (iss_accept && !(wr_frees && bus.wr_addr_i == bus.iss_addr_i)) begin
                    cnt[bus.iss_addr_i] <= iss_cnt + CNT_ONE;
                end
                if (wr_frees && !(iss_accept && bus.wr_addr_i == bus.iss_addr_i)) begin
                    cnt[bus.wr_addr_i] <= wr_cnt - CNT_ONE;
                end
            end

            // Protocol errors are still recorded in a flush cycle.
            err_q <= err_q | overflow | underflow;
        end
    end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_regfile
//
// Directed scenarios followed by randomized traffic. A reference model
// holds register contents and outstanding-write counts in plain arrays.
// -----------------------------------------------------------------------------
module tb_scoreboard_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int CNT_W  = 2;
  localparam int NREG   = 1 << ADDR_W;
  localparam int CMAX   = (1 << CNT_W) - 1;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scoreboard_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  scoreboard_regfile #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W), .ZERO_REG(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // ---------------------------------------------------------------- model
  logic [DATA_W-1:0] ref_mem [NREG];
  int                ref_cnt [NREG];
  bit                ref_err;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Writes still outstanding for register a once this cycle's write-back lands.
  function automatic int remaining(input int a);
    int n;
    n = ref_cnt[a];
    if (bus.wr_en_i && int'(bus.wr_addr_i) == a && n > 0) n = n - 1;
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int a);
    if (a == 0) return '0;
    if (bus.wr_en_i && int'(bus.wr_addr_i) == a) return bus.wr_data_i;
    return ref_mem[a];
  endfunction

  function automatic logic exp_ready();
    int a;
    a = int'(bus.iss_addr_i);
    if (a == 0) return 1'b1;
    return remaining(a) < CMAX;
  endfunction

  task automatic model_edge();
    bit ovf, unf;
    int wa, ia;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        ref_mem[r] = '0;
        ref_cnt[r] = 0;
      end
      ref_err = 1'b0;
      return;
    end
    wa  = int'(bus.wr_addr_i);
    ia  = int'(bus.iss_addr_i);
    ovf = bus.iss_en_i && !exp_ready();
    unf = bus.wr_en_i && wa != 0 && ref_cnt[wa] == 0;
    if (bus.wr_en_i && wa != 0) ref_mem[wa] = bus.wr_data_i;
    if (bus.flush_i) begin
      for (int r = 0; r < NREG; r++) ref_cnt[r] = 0;
    end else begin
      if (bus.wr_en_i && wa != 0 && ref_cnt[wa] > 0) ref_cnt[wa] = ref_cnt[wa] - 1;
      if (bus.iss_en_i && !ovf && ia != 0) ref_cnt[ia] = ref_cnt[ia] + 1;
    end
    ref_err = ref_err | ovf | unf;
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic idle();
    bus.rd_addr_i  = '0;
    bus.iss_en_i   = 1'b0;
    bus.iss_addr_i = '0;
    bus.wr_en_i    = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.flush_i    = 1'b0;
  endtask

  task automatic set_rd(input int a1, input int a0);
    bus.rd_addr_i = {ADDR_W'(a1), ADDR_W'(a0)};
  endtask

  task automatic issue(input int a);
    bus.iss_en_i   = 1'b1;
    bus.iss_addr_i = ADDR_W'(a);
  endtask

  task automatic write(input int a, input logic [DATA_W-1:0] d);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = ADDR_W'(a);
    bus.wr_data_i = d;
  endtask

  // Compare every output against the model, away from the active edge.
  task automatic sample();
    int a;
    @(negedge clk);
    for (int k = 0; k < NUM_RD; k++) begin
      a = int'(bus.rd_addr_i[k*ADDR_W +: ADDR_W]);
      check($sformatf("rd_data%0d[r%0d]", k, a), 64'(bus.rd_data_o[k*DATA_W +: DATA_W]), 64'(exp_data(a)));
      check($sformatf("rd_busy%0d[r%0d]", k, a), 64'(bus.rd_busy_o[k]), 64'(remaining(a) > 0));
    end
    check("iss_ready", 64'(bus.iss_ready_o), 64'(exp_ready()));
    check("err", 64'(bus.err_o), 64'(ref_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREG - 1));
    return int'($urandom_range(0, 7));
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    idle(); set_rd(31, 5);
    sample();
    check("reset_data", 64'(bus.rd_data_o), 64'(0));
    check("reset_busy", 64'(bus.rd_busy_o), 64'(0));
    check("reset_ready", 64'(bus.iss_ready_o), 64'(1));
    check("reset_err", 64'(bus.err_o), 64'(0));
    tick();

    // Write-through bypass, then storage
    idle(); set_rd(0, 3); write(3, 32'hDEADBEEF);
    sample();
    check("bypass_r3", 64'(bus.rd_data_o[DATA_W-1:0]), 64'h0000_0000_DEAD_BEEF);
    tick();
    idle(); set_rd(0, 3);
    sample();
    check("stored_r3", 64'(bus.rd_data_o[DATA_W-1:0]), 64'h0000_0000_DEAD_BEEF);
    tick();

    // Single RAW hazard on r7
    idle(); issue(7); step();
    idle(); set_rd(0, 7);
    sample(); check("r7_busy", 64'(bus.rd_busy_o[0]), 64'(1)); tick();
    idle(); set_rd(0, 7); write(7, 32'h12345678);
    sample();
    check("r7_wb_busy", 64'(bus.rd_busy_o[0]), 64'(0));
    check("r7_wb_data", 64'(bus.rd_data_o[DATA_W-1:0]), 64'h1234_5678);
    tick();
    idle(); set_rd(0, 7); bus.iss_addr_i = ADDR_W'(7);
    sample();
    check("r7_idle_busy", 64'(bus.rd_busy_o[0]), 64'(0));
    tick();

    // Counter saturation on r9
    for (int i = 0; i < CMAX; i++) begin
      idle(); issue(9); step();
    end
    idle(); bus.iss_addr_i = ADDR_W'(9);
    sample(); check("r9_full_ready", 64'(bus.iss_ready_o), 64'(0)); tick();
    idle(); issue(9); step();
    idle(); bus.iss_addr_i = ADDR_W'(9); set_rd(0, 9);
    sample();
    check("r9_ovf_err", 64'(bus.err_o), 64'(1));
    check("r9_still_full", 64'(bus.iss_ready_o), 64'(0));
    tick();
    idle(); issue(9); write(9, 32'hA5A5_0009);
    sample(); check("r9_swap_ready", 64'(bus.iss_ready_o), 64'(1)); tick();
    idle(); bus.iss_addr_i = ADDR_W'(9);
    sample(); check("r9_swap_full", 64'(bus.iss_ready_o), 64'(0)); tick();

    // Flush together with a write-back
    do_reset();
    idle(); issue(4); step();
    idle(); issue(6); step();
    idle(); bus.flush_i = 1'b1; write(8, 32'h55); step();
    idle(); set_rd(6, 4);
    sample(); check("flush_busy", 64'(bus.rd_busy_o), 64'(0)); tick();
    idle(); set_rd(0, 8);
    sample(); check("flush_r8", 64'(bus.rd_data_o[DATA_W-1:0]), 64'h55); tick();
    idle(); write(4, 32'h44); step();
    idle();
    sample(); check("underflow_err", 64'(bus.err_o), 64'(1)); tick();

    // Hardwired zero register
    do_reset();
    idle(); set_rd(0, 0); write(0, 32'hFFFFFFFF);
    sample(); check("r0_bypass", 64'(bus.rd_data_o), 64'(0)); tick();
    idle(); issue(0); step();
    idle(); set_rd(0, 0);
    sample();
    check("r0_data", 64'(bus.rd_data_o), 64'(0));
    check("r0_busy", 64'(bus.rd_busy_o), 64'(0));
    check("r0_ready", 64'(bus.iss_ready_o), 64'(1));
    check("r0_err", 64'(bus.err_o), 64'(0));
    tick();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      idle();
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1) issue(rand_addr());
      else bus.iss_addr_i = ADDR_W'(rand_addr());
      if ($urandom_range(0, 2) != 0) write(rand_addr(), $urandom);
      bus.flush_i = ($urandom_range(0, 31) == 0);
      set_rd(($urandom_range(0, 2) == 0) ? int'(bus.wr_addr_i) : rand_addr(),
             ($urandom_range(0, 2) == 0) ? int'(bus.iss_addr_i) : rand_addr());
      step();
    end
    rst = 1'b0;
    idle();
    step();

    // ---------------------------------------------------------------- report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
